// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default clock/baud and frame lengths.
package uart_pkg;

  localparam int unsigned DefFclk  = 100000000;
  localparam int unsigned DefFuart = 9600;

  localparam int unsigned FrameBits       = 10;
  localparam int unsigned FrameBitsParity = 11;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-clock tick every BIT_DIV+1 clocks while enabled, cleared when disabled.
module uart_baud_tick #(
  parameter int unsigned BIT_DIV = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] DivMax = 16'(BIT_DIV);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == DivMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick = enable && (cnt_q == DivMax);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned Fclk    = DefFclk,
  parameter int unsigned Fuart   = DefFuart,
  parameter int unsigned BIT_DIV = (Fclk / Fuart) - 1
) (
  input  logic       clk_Tx,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       tx_start,
  output logic       Tx_out,
  output logic       busy,
  output logic       done
);

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  uart_baud_tick #(
    .BIT_DIV(BIT_DIV)
  ) u_baud (
    .clk   (clk_Tx),
    .rst_n (rst_n),
    .enable(state_q != StIdle),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d = StStart;
          shift_d = data_in;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        // Frame ends here; the done cycle is IDLE, so a new start is accepted right after.
        if (tick) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_Tx) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign Tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
